// File: rtl/keypad_pkg.sv
// Shared key codes and FSM state encoding for the keypad entry controller.
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP = 4'd10;
  localparam logic [3:0] KEY_CLR  = 4'd11;
  localparam logic [3:0] KEY_ENT  = 4'd15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_ignored(input logic [3:0] k);
    return (k >= 4'd12) && (k <= 4'd14);
  endfunction

endpackage

// File: rtl/entry_timeout_timer.sv
// Idle counter for a partial entry; expire stays high once the limit is reached
// until the counter is restarted or disabled.
module entry_timeout_timer #(
  parameter int TIMEOUT_CYC = 250000000,
  parameter int CNT_W       = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!en || restart) begin
      r_cnt <= '0;
    end else if (r_cnt != LAST) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expire = en && (r_cnt == LAST);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Assembles scanner key events into multi-digit BCD entries and hands each
// completed entry to a consumer.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int TIMEOUT_CYC = 250000000,
  parameter int CNT_W       = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_flag,
  input  logic [3:0]          key_value,
  output logic [4*DIGITS-1:0] live_bcd,
  output logic [3:0]          live_count,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [3:0]          out_count,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                err_pulse,
  output logic                timeout_pulse,
  output logic [1:0]          dbg_state
);

  localparam int         W    = 4 * DIGITS;
  localparam logic [3:0] FULL = 4'(DIGITS);

  // Handshake: out_bcd/out_count are held stable while out_valid is high; the
  // entry transfers on a cycle where out_valid && out_ready, and out_valid
  // drops on the following cycle. out_ready is ignored when out_valid is low.

  state_t         r_state, w_state_nxt;
  logic           r_flag_d, w_kev, w_expire, w_restart;
  logic [W-1:0]   r_buf, w_buf_nxt, r_out_bcd, w_out_bcd_nxt;
  logic [3:0]     r_cnt, w_cnt_nxt, r_out_cnt, w_out_cnt_nxt;
  logic           r_out_valid, w_out_valid_nxt;
  logic           r_err, w_err_nxt, r_to, w_to_nxt, r_busy;

  assign w_kev = key_flag && !r_flag_d;

  entry_timeout_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (r_state == ENTRY),
    .restart (w_restart),
    .expire  (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_kev && is_digit(key_value)) w_state_nxt = ENTRY;
      ENTRY: begin
        if (w_kev) begin
          if (key_value == KEY_CLR)                        w_state_nxt = IDLE;
          else if (key_value == KEY_ENT)                   w_state_nxt = HOLD;
          else if (key_value == KEY_BKSP && r_cnt == 4'd1) w_state_nxt = IDLE;
        end else if (w_expire) begin
          w_state_nxt = IDLE;
        end
      end
      HOLD:    if (r_out_valid && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_buf_nxt       = r_buf;
    w_cnt_nxt       = r_cnt;
    w_out_bcd_nxt   = r_out_bcd;
    w_out_cnt_nxt   = r_out_cnt;
    w_out_valid_nxt = r_out_valid;
    w_err_nxt       = 1'b0;
    w_to_nxt        = 1'b0;
    w_restart       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_kev && is_digit(key_value)) begin
          w_buf_nxt = W'(key_value);
          w_cnt_nxt = 4'd1;
          w_restart = 1'b1;
        end else if (w_kev && key_value == KEY_ENT) begin
          w_err_nxt = 1'b1;
        end
      end
      ENTRY: begin
        // A key arriving on the expiry cycle takes priority over the timeout.
        if (w_kev && is_digit(key_value)) begin
          w_restart = 1'b1;
          if (r_cnt == FULL) begin
            w_err_nxt = 1'b1;
          end else begin
            w_buf_nxt = (r_buf << 4) | W'(key_value);
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else if (w_kev && key_value == KEY_BKSP) begin
          w_buf_nxt = r_buf >> 4;
          w_cnt_nxt = r_cnt - 4'd1;
          w_restart = 1'b1;
        end else if (w_kev && key_value == KEY_CLR) begin
          w_buf_nxt = '0;
          w_cnt_nxt = 4'd0;
        end else if (w_kev && key_value == KEY_ENT) begin
          w_out_bcd_nxt   = r_buf;
          w_out_cnt_nxt   = r_cnt;
          w_out_valid_nxt = 1'b1;
          w_buf_nxt       = '0;
          w_cnt_nxt       = 4'd0;
        end else if (!w_kev && w_expire) begin
          w_buf_nxt = '0;
          w_cnt_nxt = 4'd0;
          w_to_nxt  = 1'b1;
        end
      end
      HOLD: begin
        if (w_kev && !is_ignored(key_value)) w_err_nxt = 1'b1;
        if (r_out_valid && out_ready)        w_out_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // flag_d resets high so a key already held at reset release is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_d    <= 1'b1;
      r_buf       <= '0;
      r_cnt       <= 4'd0;
      r_out_bcd   <= '0;
      r_out_cnt   <= 4'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_to        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_flag_d    <= key_flag;
      r_buf       <= w_buf_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_bcd   <= w_out_bcd_nxt;
      r_out_cnt   <= w_out_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_err       <= w_err_nxt;
      r_to        <= w_to_nxt;
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign live_bcd      = r_buf;
  assign live_count    = r_cnt;
  assign out_bcd       = r_out_bcd;
  assign out_count     = r_out_cnt;
  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign err_pulse     = r_err;
  assign timeout_pulse = r_to;
  assign dbg_state     = r_state;

endmodule
